cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Common-data-bus (CDB) arbiter and broadcaster for the Tomasulo core.
- Functional units (FUs) hand finished results to this block. It buffers one result per FU and broadcasts at most one {tag, data} per cycle to the reservation stations and the register bank.
- It is the transmit end of the result bus that the reservation stations and the register status logic receive on.

Parameters:
- NUM_FU, 4: number of functional-unit result ports. Must be a power of 2, at least 2.
- TAG_W, 4: reservation-station tag width. Tag 0 is reserved and means "no producer".
- DATA_W, 16: result data width.
- SRC_W, 2: log2(NUM_FU), the width of the source index.

Ports:
- clk1  input  1  single clock; all state updates on posedge clk1.
- rst_n  input  1  asynchronous active-low reset.
- fu_valid  input  NUM_FU  bit i: FU i presents a result.
- fu_ready  output  NUM_FU  bit i: buffer i accepts this cycle.
- fu_tag  input  NUM_FU*TAG_W  FU i tag at bits [i*TAG_W +: TAG_W].
- fu_data  input  NUM_FU*DATA_W  FU i data at bits [i*DATA_W +: DATA_W].
- flush  input  1  synchronous squash of all pending results.
- cdb_valid  output  1  broadcast valid, asserted for exactly one cycle per result.
- cdb_tag  output  TAG_W  broadcast tag.
- cdb_data  output  DATA_W  broadcast value.
- cdb_src  output  SRC_W  index of the FU that produced the broadcast.
- pending_cnt  output  SRC_W+1  number of occupied holding buffers.
- drop_err  output  1  sticky; set when a tag-0 result is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all holding buffers empty; rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, pending_cnt=0, drop_err=0.
  - Applies mid-operation too: all pending results are lost and no broadcast follows reset release.
- Holding buffers:
  - One entry per FU: hv[i], htag[i], hdata[i].
  - fu_ready[i] = !flush && (!hv[i] || grant[i]). This is combinational from hv, grant and flush.
  - Accept on posedge when fu_valid[i] && fu_ready[i]: hv[i]<=1 and the tag/data are captured.
- Tag-0 results:
  - Accepted, then dropped: hv[i] stays 0 and drop_err<=1.
  - drop_err clears only on reset.
- Arbitration (combinational, evaluated before the edge):
  - Among entries with hv set, pick the first index at or after rr_ptr, wrapping modulo NUM_FU.
  - grant is one-hot or zero.
- Broadcast (on posedge):
  - If a grant exists: cdb_valid<=1 and cdb_tag, cdb_data, cdb_src take the winner's values; hv[winner] is cleared, unless the same edge reloads it; rr_ptr<=winner+1 mod NUM_FU.
  - If no grant: cdb_valid<=0. cdb_tag, cdb_data and cdb_src hold their previous values; rr_ptr holds.
- Latency:
  - A result accepted at edge N is broadcast at the earliest at edge N+1, visible during cycle N+1.
  - There is no combinational path from fu_* to cdb_*.
- Throughput: one broadcast per cycle. Each FU sustains one result every cycle while it keeps winning, because grant and re-accept can happen on the same edge.
- Fairness: under full load every FU is granted once every NUM_FU cycles, with no starvation.
- Flush:
  - At the edge where flush=1: all hv<=0, cdb_valid<=0, and there are no accepts.
  - rr_ptr holds; drop_err holds.
- pending_cnt: popcount of hv, registered, reflecting the post-edge state.
- Simultaneous flush and rst_n low: reset dominates.

Test Plan:
- Reset mid-stream: fill 3 buffers, pulse rst_n low → all outputs 0 at once; no cdb_valid after release.
- Single result: FU2 sends tag=5, data=0x00AB at edge 1 → cdb_valid=1, tag=5, data=0x00AB, src=2 during cycle after edge 2; pending_cnt 1 then 0.
- Round-robin under full load:
  - All 4 FUs hold fu_valid=1 every cycle with tags 1..4; rr_ptr=0.
  - Required: broadcast src sequence is 0,1,2,3,0,1…; every fu_ready pulses once per 4 cycles; cdb_valid=1 each cycle.
- Back-pressure: FU1 presents tag 7 while hv[1]=1 and FU1 is not granted → fu_ready[1]=0 and the held tag is unchanged; accepted only on the cycle FU1 wins.
- Tag 0: FU3 sends tag=0 → no broadcast, drop_err=1 persists, fu_ready[3] stays 1.
- Flush: 4 entries pending, flush for one cycle → next cycle cdb_valid=0 and pending_cnt=0; a result presented during flush is not accepted.

Source files
------------

// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
// Common-data-bus arbiter/broadcaster for the Tomasulo core. Each functional
// unit owns a single holding buffer; one buffered {tag, data} is broadcast per
// cycle, picked round-robin starting at rr_ptr.
//
// Ports
//   clk1         single clock, rising edge
//   rst_n        asynchronous active-low reset
//   fu_valid     per-FU result valid
//   fu_ready     per-FU accept (combinational from hv, grant and flush)
//   fu_tag       packed per-FU tags, FU i at [i*TAG_W +: TAG_W]
//   fu_data      packed per-FU data, FU i at [i*DATA_W +: DATA_W]
//   flush        synchronous squash of all pending results
//   cdb_valid    registered broadcast valid, one cycle per result
//   cdb_tag      registered broadcast tag
//   cdb_data     registered broadcast data
//   cdb_src      registered index of the producing FU
//   pending_cnt  registered number of occupied holding buffers
//   drop_err     sticky flag, a tag-0 result was accepted
// -----------------------------------------------------------------------------
module cdb_broadcaster #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SRC_W  = 2
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [SRC_W-1:0]         cdb_src,
    output logic [SRC_W:0]           pending_cnt,
    output logic                     drop_err
);

    localparam int unsigned CNT_W = SRC_W + 1;

    logic [NUM_FU-1:0] hv;
    logic [NUM_FU-1:0] hv_nxt;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] acc;
    logic [NUM_FU-1:0] zero_acc;
    logic [TAG_W-1:0]  htag  [NUM_FU];
    logic [DATA_W-1:0] hdata [NUM_FU];
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  win;
    logic [SRC_W-1:0]  idx;
    logic              found;
    logic [CNT_W-1:0]  cnt_nxt;

    // Round-robin pick: first occupied entry at or after rr_ptr. NUM_FU is a
    // power of two, so the SRC_W-bit add wraps modulo NUM_FU for free.
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = SRC_W'(rr_ptr + SRC_W'(k));
            if (!found && hv[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
    end

    // A buffer can take a new result when empty or when it is draining this edge.
    assign fu_ready = flush ? '0 : (~hv | grant);

    // Next occupancy: granted entries drain, accepted non-zero tags fill.
    always_comb begin
        acc      = fu_valid & fu_ready;
        zero_acc = '0;
        hv_nxt   = hv & ~grant;
        cnt_nxt  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (acc[i]) begin
                if (fu_tag[i*TAG_W +: TAG_W] == '0) begin
                    zero_acc[i] = 1'b1;
                end else begin
                    hv_nxt[i] = 1'b1;
                end
            end
        end
        if (flush) begin
            hv_nxt = '0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(hv_nxt[i]);
        end
    end

    // Holding buffers and occupancy count.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            hv          <= '0;
            pending_cnt <= '0;
            drop_err    <= 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                htag[i]  <= '0;
                hdata[i] <= '0;
            end
        end else begin
            hv          <= hv_nxt;
            pending_cnt <= cnt_nxt;
            if (|zero_acc) begin
                drop_err <= 1'b1;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) begin
                    htag[i]  <= fu_tag[i*TAG_W +: TAG_W];
                    hdata[i] <= fu_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Broadcast register; payload holds its last value when idle or flushed.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (found) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= htag[win];
            cdb_data  <= hdata[win];
            cdb_src   <= win;
            rr_ptr    <= SRC_W'(win + SRC_W'(1));
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// tb_cdb_broadcaster
// Self-checking bench for cdb_broadcaster. Expected broadcasts are queued when
// stimulus is driven and compared by a negedge monitor as cdb_valid fires;
// per-scenario tasks check ready, occupancy, flags and reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_cdb_broadcaster;

    logic        clk1;
    logic        rst_n;
    logic [3:0]  fu_valid;
    logic [3:0]  fu_ready;
    logic [15:0] fu_tag;
    logic [63:0] fu_data;
    logic        flush;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [1:0]  cdb_src;
    logic [2:0]  pending_cnt;
    logic        drop_err;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] data;
        logic [1:0]  src;
    } bc_t;

    bc_t exp_q[$];
    bc_t mon_e;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    cdb_broadcaster #(
        .NUM_FU (4),
        .TAG_W  (4),
        .DATA_W (16),
        .SRC_W  (2)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_tag      (fu_tag),
        .fu_data     (fu_data),
        .flush       (flush),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_src     (cdb_src),
        .pending_cnt (pending_cnt),
        .drop_err    (drop_err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Broadcast monitor: every cdb_valid must match the oldest queued entry.
    always @(negedge clk1) begin
        if (mon_en && rst_n && cdb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bcast_unexpected: got tag=%0d data=%h src=%0d, expected no broadcast",
                         cdb_tag, cdb_data, cdb_src);
            end else begin
                mon_e = exp_q.pop_front();
                if ({cdb_tag, cdb_data, cdb_src} !== {mon_e.tag, mon_e.data, mon_e.src}) begin
                    errors++;
                    $display("FAIL bcast_payload: got tag=%0d data=%h src=%0d, expected tag=%0d data=%h src=%0d",
                             cdb_tag, cdb_data, cdb_src, mon_e.tag, mon_e.data, mon_e.src);
                end
            end
        end
    end

    task automatic set_fu(input int i, input logic v, input logic [3:0] t, input logic [15:0] d);
        fu_valid[i]          = v;
        fu_tag[i*4 +: 4]     = t;
        fu_data[i*16 +: 16]  = d;
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [15:0] d, input logic [1:0] s);
        bc_t e;
        e.tag  = t;
        e.data = d;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    // Leaves the DUT freshly reset, returning 1 time unit after a rising edge.
    task automatic reset_dut();
        mon_en   = 1'b0;
        exp_q.delete();
        fu_valid = '0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #3;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== 23'd0) begin
            errors++;
            $display("FAIL reset_cdb: got valid=%b tag=%0d data=%h src=%0d, expected all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        checks++;
        if (pending_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_pending: got %0d, expected 0", pending_cnt);
        end
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_err: got %b, expected 0", drop_err);
        end
        checks++;
        if (fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1111", fu_ready);
        end
        @(negedge clk1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b pending=%0d, expected 0 and 0", cdb_valid, pending_cnt);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic test_single();
        set_fu(2, 1'b1, 4'd5, 16'h00AB);
        push_exp(4'd5, 16'h00AB, 2'd2);
        @(posedge clk1);
        #1;
        fu_valid = '0;
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd1 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got pending=%0d valid=%b, expected 1 and 0", pending_cnt, cdb_valid);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd0 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_bcast: got pending=%0d valid=%b, expected 0 and 1", pending_cnt, cdb_valid);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 4'd5 || cdb_src !== 2'd2) begin
            errors++;
            $display("FAIL single_hold: got valid=%b tag=%0d src=%0d, expected 0, 5, 2", cdb_valid, cdb_tag, cdb_src);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset_mid();
        set_fu(0, 1'b1, 4'd1, 16'h0A01);
        set_fu(1, 1'b1, 4'd2, 16'h0A02);
        set_fu(2, 1'b1, 4'd3, 16'h0A03);
        push_exp(4'd1, 16'h0A01, 2'd0);
        @(posedge clk1);
        #1;
        fu_valid = '0;
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd3) begin
            errors++;
            $display("FAIL rmid_fill: got pending=%0d, expected 3", pending_cnt);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (cdb_valid !== 1'b1 || pending_cnt !== 3'd2) begin
            errors++;
            $display("FAIL rmid_bcast: got valid=%b pending=%0d, expected 1 and 2", cdb_valid, pending_cnt);
        end
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src, pending_cnt, drop_err} !== 27'd0) begin
            errors++;
            $display("FAIL rmid_async: got valid=%b tag=%0d data=%h src=%0d pending=%0d drop=%b, expected all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src, pending_cnt, drop_err);
        end
        @(posedge clk1);
        @(negedge clk1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk1);
            #1;
            @(negedge clk1);
            checks++;
            if (cdb_valid !== 1'b0 || pending_cnt !== 3'd0) begin
                errors++;
                $display("FAIL rmid_after_%0d: got valid=%b pending=%0d, expected 0 and 0", c, cdb_valid, pending_cnt);
            end
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic test_round_robin();
        int         seq[4];
        logic [3:0] exp_rdy;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            set_fu(i, 1'b1, 4'(i + 1), {4'(i), 12'(seq[i])});
        end
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk1);
            exp_rdy = (n == 1) ? 4'hF : 4'(1 << ((n - 2) % 4));
            checks++;
            if (fu_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready_%0d: got %b, expected %b", n, fu_ready, exp_rdy);
            end
            if (n >= 3) begin
                checks++;
                if (cdb_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_valid_%0d: got %b, expected 1", n, cdb_valid);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) push_exp(4'(i + 1), {4'(i), 12'(seq[i])}, 2'(i));
            end
            @(posedge clk1);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) begin
                    seq[i]++;
                    set_fu(i, 1'b1, 4'(i + 1), {4'(i), 12'(seq[i])});
                end
            end
        end
        fu_valid = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk1);
            checks++;
            if (cdb_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_drain_%0d: got valid=%b, expected 1", k, cdb_valid);
            end
            @(posedge clk1);
            #1;
        end
        @(negedge clk1);
        checks++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rr_empty: got valid=%b pending=%0d, expected 0 and 0", cdb_valid, pending_cnt);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic test_back_pressure();
        reset_dut();
        set_fu(0, 1'b1, 4'd3, 16'h0300);
        set_fu(1, 1'b1, 4'd6, 16'h0600);
        push_exp(4'd3, 16'h0300, 2'd0);
        push_exp(4'd6, 16'h0600, 2'd1);
        @(posedge clk1);
        #1;
        fu_valid[0] = 1'b0;
        set_fu(1, 1'b1, 4'd7, 16'h0700);
        @(negedge clk1);
        checks++;
        if (fu_ready[1] !== 1'b0 || pending_cnt !== 3'd2) begin
            errors++;
            $display("FAIL bp_blocked: got ready1=%b pending=%0d, expected 0 and 2", fu_ready[1], pending_cnt);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (fu_ready[1] !== 1'b1 || pending_cnt !== 3'd1 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_winning: got ready1=%b pending=%0d valid=%b, expected 1, 1, 1",
                     fu_ready[1], pending_cnt, cdb_valid);
        end
        push_exp(4'd7, 16'h0700, 2'd1);
        @(posedge clk1);
        #1;
        fu_valid = '0;
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd1 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_reaccept: got pending=%0d valid=%b, expected 1 and 1", pending_cnt, cdb_valid);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd0 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: got pending=%0d valid=%b, expected 0 and 1", pending_cnt, cdb_valid);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic test_tag0();
        @(negedge clk1);
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL tag0_pre: got drop_err=%b, expected 0", drop_err);
        end
        set_fu(3, 1'b1, 4'd0, 16'hDEAD);
        #1;
        checks++;
        if (fu_ready[3] !== 1'b1) begin
            errors++;
            $display("FAIL tag0_ready_a: got %b, expected 1", fu_ready[3]);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (fu_ready[3] !== 1'b1 || drop_err !== 1'b1 || pending_cnt !== 3'd0) begin
            errors++;
            $display("FAIL tag0_drop: got ready3=%b drop=%b pending=%0d, expected 1, 1, 0",
                     fu_ready[3], drop_err, pending_cnt);
        end
        @(posedge clk1);
        #1;
        fu_valid = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk1);
            checks++;
            if (cdb_valid !== 1'b0 || drop_err !== 1'b1) begin
                errors++;
                $display("FAIL tag0_sticky_%0d: got valid=%b drop=%b, expected 0 and 1", c, cdb_valid, drop_err);
            end
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            set_fu(i, 1'b1, 4'(i + 1), 16'(16'hF000 + i));
        end
        @(posedge clk1);
        #1;
        fu_valid = '0;
        set_fu(0, 1'b1, 4'd9, 16'h0909);
        flush = 1'b1;
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd4 || fu_ready !== 4'h0) begin
            errors++;
            $display("FAIL flush_pre: got pending=%0d ready=%b, expected 4 and 0000", pending_cnt, fu_ready);
        end
        @(posedge clk1);
        #1;
        flush    = 1'b0;
        fu_valid = '0;
        @(negedge clk1);
        checks++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 3'd0 || drop_err !== 1'b1) begin
            errors++;
            $display("FAIL flush_edge: got valid=%b pending=%0d drop=%b, expected 0, 0, 1",
                     cdb_valid, pending_cnt, drop_err);
        end
        @(posedge clk1);
        #1;
        @(negedge clk1);
        checks++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 3'd0) begin
            errors++;
            $display("FAIL flush_after: got valid=%b pending=%0d, expected 0 and 0", cdb_valid, pending_cnt);
        end
        // Pointer was 2 before the flush, so FU3 must win ahead of FU0.
        set_fu(0, 1'b1, 4'hA, 16'h0A0A);
        set_fu(3, 1'b1, 4'hB, 16'h0B0B);
        push_exp(4'hB, 16'h0B0B, 2'd3);
        push_exp(4'hA, 16'h0A0A, 2'd0);
        @(posedge clk1);
        #1;
        fu_valid = '0;
        repeat (2) begin
            @(posedge clk1);
            #1;
        end
        @(negedge clk1);
        checks++;
        if (pending_cnt !== 3'd0) begin
            errors++;
            $display("FAIL flush_rr_drain: got pending=%0d, expected 0", pending_cnt);
        end
        @(posedge clk1);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_back_pressure();
        test_tag0();
        test_flush();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bcast_missing: got %0d outstanding broadcasts, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
